button_encoder: RTL and testbench

Input-side counterpart of the registered 3-to-8 active-low LED decoder. It samples eight active-low push-button lines, synchronises and debounces each one, and detects press events. Press events are queued in a pending mask and handed out one at a time as a 3-bit button code over a valid/ready handshake. It sits between the board switch pins and whatever control logic consumes button presses.

---
 rtl/button_encoder_if.sv | 19 +
 rtl/button_encoder.sv | 138 +++++++++++++
 tb/tb_button_encoder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_encoder_if.sv
// Press-event handshake between the button encoder and its consumer.
// The encoder drives code/valid; the consumer drives ready.
interface button_encoder_if;
    logic [2:0] code;
    logic       valid;
    logic       ready;

    modport master (
        output code,
        output valid,
        input  ready
    );

    modport slave (
        input  code,
        input  valid,
        output ready
    );
endinterface

// File: rtl/button_encoder.sv
// Eight active-low buttons: synchronise, debounce, detect presses, queue them in a pending mask
// and hand them out one at a time, lowest index first, as a 3-bit code over valid/ready.
module button_encoder #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       btn_n,
    button_encoder_if.master evt,
    output logic [7:0]       level,
    output logic             overflow
);

    localparam int unsigned     CntW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

    // Two-flop synchroniser, resets to released.
    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;

    // Per-line debounce counters and debounced level.
    logic [7:0][CntW-1:0] cnt_q, cnt_d;
    logic [7:0]           db_q, db_d;
    logic [7:0]           flip;
    logic [7:0]           press;

    // Pending mask and output slot.
    logic [7:0] pend_q, pend_d;
    logic [7:0] load_mask;
    logic [2:0] low_idx;
    logic       slot_free;
    logic       load;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       overflow_q, overflow_d;

    always_comb begin
        s1_d = btn_n;
        s2_d = s1_q;
    end

    // Any cycle that agrees with the debounced level restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        flip  = '0;
        for (int i = 0; i < 8; i++) begin
            if (~s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                db_d[i]  = ~db_q[i];
                cnt_d[i] = '0;
                flip[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // Only rising debounced edges are events; releases are silent.
    always_comb begin
        press = flip & ~db_q;
    end

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    always_comb begin
        slot_free = !valid_q || evt.ready;
        load      = slot_free && (pend_q != 8'd0);
        load_mask = load ? (8'd1 << low_idx) : 8'd0;
    end

    // A press on a bit being loaded this edge re-sets it rather than overflowing.
    always_comb begin
        pend_d     = (pend_q & ~load_mask) | press;
        overflow_d = overflow_q | (|(press & pend_q & ~load_mask));
    end

    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        if (slot_free) begin
            valid_d = load;
            if (load) begin
                code_d = low_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 8'hff;
            s2_q <= 8'hff;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            db_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q     <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        evt.code  = code_q;
        evt.valid = valid_q;
        level     = db_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_button_encoder.sv
// Bench for button_encoder: directed scenarios with literal expectations plus a random run,
// all continuously compared against a run-length/pending-set model of the encoder.
module tb_button_encoder;

    localparam int unsigned Deb = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] btn_n = 8'hff;
    logic [7:0] level;
    logic       overflow;

    button_encoder_if u_if ();

    button_encoder #(
        .DEBOUNCE(Deb)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_n   (btn_n),
        .evt     (u_if),
        .level   (level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sampled pipeline, disagreement run lengths, pending set, one slot.
    logic [7:0] m_s1, m_s2, m_db, m_pend;
    int         m_run[8];
    logic [2:0] m_code;
    logic       m_valid, m_ovf;
    bit         chk_en = 1'b0;

    task automatic model_reset();
        m_s1 = 8'hff; m_s2 = 8'hff; m_db = '0; m_pend = '0;
        m_code = '0; m_valid = 1'b0; m_ovf = 1'b0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [7:0] pr;
        logic [7:0] low;
        pr  = '0;
        low = '0;
        for (int i = 0; i < 8; i++) begin
            if ((~m_s2[i]) != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == Deb) begin
                    m_db[i]  = ~m_db[i];
                    m_run[i] = 0;
                    pr[i]    = m_db[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (!m_valid || u_if.ready) begin
            if (m_pend != 8'd0) begin
                low     = m_pend & (~m_pend + 8'd1);
                m_code  = 3'($clog2(low));
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_ovf  = m_ovf | (|(pr & m_pend & ~low));
        m_pend = (m_pend & ~low) | pr;
        m_s2   = m_s1;
        m_s1   = btn_n;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("model_level", level, m_db);
            check("model_valid", u_if.valid, m_valid);
            check("model_code", u_if.code, m_code);
            check("model_overflow", overflow, m_ovf);
        end
    end

    int hs_cnt = 0;
    always @(posedge clk) begin
        if (rst && u_if.valid && u_if.ready) hs_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        btn_n      = 8'hff;
        u_if.ready = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  k;
        int  b;
        bit  got;
        u_if.ready = 1'b0;
        step(1);
        chk_en = 1'b1;
        check("reset_code", u_if.code, 3'd0);
        check("reset_valid", u_if.valid, 1'b0);
        check("reset_level", level, 8'h00);
        check("reset_overflow", overflow, 1'b0);
        do_reset();

        // Clean press of button 2.
        u_if.ready = 1'b1;
        btn_n      = 8'hfb;
        step(5);
        check("clean_level_e5", level, 8'h00);
        step(1);
        check("clean_level_e6", level, 8'h04);
        check("clean_valid_e6", u_if.valid, 1'b0);
        step(1);
        check("clean_valid_e7", u_if.valid, 1'b1);
        check("clean_code_e7", u_if.code, 3'd2);
        step(1);
        check("clean_valid_e8", u_if.valid, 1'b0);
        check("clean_overflow", overflow, 1'b0);

        // Bounce rejection on button 5.
        do_reset();
        u_if.ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            btn_n = (((j / 2) % 2) == 0) ? 8'hdf : 8'hff;
            step(1);
            check("bounce_level", level, 8'h00);
            check("bounce_valid", u_if.valid, 1'b0);
        end
        btn_n = 8'hdf;
        got   = 1'b0;
        for (k = 0; k < 12 && !got; k++) begin
            step(1);
            if (u_if.valid) got = 1'b1;
        end
        check("bounce_event_seen", got, 1'b1);
        check("bounce_latency", k, 7);
        check("bounce_code", u_if.code, 3'd5);

        // Simultaneous presses of 0, 4, 7 under backpressure.
        do_reset();
        btn_n = 8'h6e;
        step(7);
        check("simul_valid", u_if.valid, 1'b1);
        check("simul_code0", u_if.code, 3'd0);
        step(3);
        check("simul_hold", u_if.code, 3'd0);
        u_if.ready = 1'b1;
        step(1);
        check("simul_code4", u_if.code, 3'd4);
        check("simul_valid4", u_if.valid, 1'b1);
        step(1);
        check("simul_code7", u_if.code, 3'd7);
        check("simul_valid7", u_if.valid, 1'b1);
        step(1);
        check("simul_drain", u_if.valid, 1'b0);

        // Overflow: slot holds 1, button 3 pending, then re-pressed.
        do_reset();
        btn_n = 8'hfd;
        step(8);
        btn_n = 8'hf5;
        step(8);
        check("ovf_before", overflow, 1'b0);
        btn_n = 8'hfd;
        step(8);
        btn_n = 8'hf5;
        step(8);
        check("ovf_set", overflow, 1'b1);
        check("ovf_slot_code", u_if.code, 3'd1);
        u_if.ready = 1'b1;
        step(1);
        check("ovf_code3", u_if.code, 3'd3);
        check("ovf_valid3", u_if.valid, 1'b1);
        step(1);
        check("ovf_single_event", u_if.valid, 1'b0);
        step(3);
        check("ovf_sticky", overflow, 1'b1);

        // Backpressure stability.
        do_reset();
        btn_n = 8'hfd;
        step(8);
        check("bp_code1", u_if.code, 3'd1);
        btn_n = 8'hbd;
        for (int j = 0; j < 10; j++) begin
            step(1);
            check("bp_hold_code", u_if.code, 3'd1);
            check("bp_hold_valid", u_if.valid, 1'b1);
        end
        u_if.ready = 1'b1;
        step(1);
        check("bp_code6", u_if.code, 3'd6);
        check("bp_valid6", u_if.valid, 1'b1);

        // Reset mid-debounce while button 2 is already registered.
        do_reset();
        btn_n = 8'hfb;
        step(8);
        check("rst_pre_level", level, 8'h04);
        check("rst_pre_valid", u_if.valid, 1'b1);
        btn_n = 8'hfa;
        step(2);
        rst = 1'b0;
        #1;
        check("rst_async_level", level, 8'h00);
        check("rst_async_valid", u_if.valid, 1'b0);
        check("rst_async_code", u_if.code, 3'd0);
        check("rst_async_ovf", overflow, 1'b0);
        step(2);
        rst        = 1'b1;
        u_if.ready = 1'b1;
        step(5);
        check("rst_level0_e5", level[0], 1'b0);
        step(1);
        check("rst_level0_e6", level[0], 1'b1);
        check("rst_level_e6", level, 8'h05);
        step(1);
        check("rst_valid_e7", u_if.valid, 1'b1);
        check("rst_code_e7", u_if.code, 3'd0);
        step(1);
        check("rst_code_e8", u_if.code, 3'd2);

        // Random run, model compared every cycle.
        do_reset();
        hs_cnt = 0;
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 5) == 0) begin
                b        = $urandom_range(0, 7);
                btn_n[b] = ~btn_n[b];
            end
            u_if.ready = ($urandom_range(0, 3) != 0);
            if (j == 1500) begin
                rst = 1'b0;
                step(1);
                rst = 1'b1;
            end
            step(1);
        end
        check("random_handshakes", (hs_cnt > 0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
